dmem_block_mover: RTL and testbench
===================================

Name: dmem_block_mover

Overview:
- Bus initiator for the data-memory port: the CPU-side end of the addr / write_data / memread / memwrite / read_data / sign_mask / clk_stall interface.
- Performs word block transfers on that port without the processor: either COPY (src→dst) or FILL (constant→dst).
- Used for boot-time zeroing and buffer moves while the processor is held off the port by the top-level mux.
- Honours the data memory's clk_stall busy indication.

Parameters:
- ADDR_W, 32, width of memory addresses (byte addressed).
- LEN_W, 16, width of the transfer length in words.
- STALL_TIMEOUT, 255, max consecutive stalled cycles per access before aborting with error.

Ports:
- clk  input  1  system clock; same clock as data memory.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  one-cycle pulse; latches cfg_* when idle.
- cfg_mode  input  1  0 = COPY, 1 = FILL.
- cfg_src  input  ADDR_W  COPY source byte address.
- cfg_dst  input  ADDR_W  destination byte address.
- cfg_len  input  LEN_W  number of 32-bit words to transfer.
- cfg_fill  input  32  FILL data word.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse at completion, including error completion.
- err  output  1  sticky error; cleared by the next accepted start.
- mem_addr  output  ADDR_W  to data memory addr.
- mem_wdata  output  32  to data memory write_data.
- mem_read  output  1  to data memory memread.
- mem_write  output  1  to data memory memwrite.
- mem_sign_mask  output  4  to data memory sign_mask; constant SM_WORD during accesses.
- mem_rdata  input  32  from data memory read_data.
- mem_stall  input  1  from data memory clk_stall.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - all outputs 0; state IDLE; counters cleared.
  - Applies mid-transfer: mem_read and mem_write drop on that edge, and no done pulse is produced.
- Start acceptance:
  - start is accepted only in IDLE; start while busy is ignored.
  - Accept: latch cfg_* with address bits [1:0] forced to 0; err cleared; busy=1 from the next cycle.
  - If cfg_src[1:0]≠0 (COPY only) or cfg_dst[1:0]≠0, err=1.
  - cfg_len==0 → done pulses the cycle after start, busy never rises, no bus activity.
- State machine:
  - IDLE → (COPY) RD_REQ / (FILL) WR_REQ.
  - RD_REQ: mem_read=1, mem_addr=src. Next state RD_WAIT.
  - RD_WAIT:
    - hold mem_read and mem_addr.
    - When mem_stall==0, capture mem_rdata into the data register, drop mem_read, go to WR_REQ.
  - WR_REQ: mem_write=1, mem_addr=dst, mem_wdata = data register (COPY) or cfg_fill (FILL). Next state WR_WAIT.
  - WR_WAIT:
    - hold all request signals.
    - When mem_stall==0, drop mem_write, then src+=4, dst+=4, remaining−=1.
    - If remaining becomes 0 → DONE; else → RD_REQ (COPY) or WR_REQ (FILL).
  - DONE: done=1 for one cycle, busy=0, then → IDLE.
- Handshake rules:
  - mem_read and mem_write are never both 1.
  - Request signals are stable from the REQ state until completion.
  - mem_stall is ignored in the REQ cycle itself (memory raises stall one cycle after request).
  - Minimum 2 cycles per access; FILL minimum 2 cycles/word, COPY 4 cycles/word.
- Timeout:
  - A stall counter counts consecutive stalled WAIT cycles.
  - When it reaches STALL_TIMEOUT: drop the request, set err=1, go to DONE.
- Address arithmetic:
  - increments are modulo 2^ADDR_W; wrap past the top of the address space is allowed and not flagged.
- Overlap:
  - COPY with dst>src and overlapping ranges is not corrected; behaviour is forward-copy order.

Decomposition:
- Package dmem_pkg:
  - SM_WORD = 4'b0010 (unsigned word access code used by data memory).
  - mover state enum {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE}.
  - mode constants MODE_COPY = 0, MODE_FILL = 1.
- Sub-module dmem_stall_timer: stall counter with clear/enable inputs and expired output, parameterised by STALL_TIMEOUT.

Test Plan:
- FILL: dst=0x100, len=4, fill=0xDEADBEEF, memory model stall=0 → four writes to 0x100/104/108/10C, each 2 cycles; done 9 cycles after start; err=0.
- COPY with 3-cycle read stall: src=0x0 preloaded {1,2,3}, dst=0x40, len=3 → words 1,2,3 at 0x40–0x48; mem_read held through the stall; done pulses once.
- cfg_len=0 → done one cycle after start; busy stays 0; mem_read and mem_write never assert.
- Misaligned or busy start: dst=0x102 → err=1, done pulse, no writes. A second start while busy is ignored; the original transfer completes unchanged.
- Timeout: STALL_TIMEOUT=8, model holds stall=1 → request drops after 8 stalled cycles; err=1; done=1; next start clears err.
- Reset mid-COPY (in RD_WAIT) → next edge: all outputs 0, no done pulse; a fresh start then runs normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and state encoding for the data-memory block mover
package dmem_pkg;
  localparam logic [3:0] SM_WORD = 4'b0010;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_e;
endpackage

// File: rtl/dmem_stall_timer.sv
// dmem_stall_timer: counts consecutive stalled wait cycles and flags the last allowed one
module dmem_stall_timer #(
  parameter int STALL_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(STALL_TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expired = en && cnt == W'(STALL_TIMEOUT - 1);
  // consecutive stall count, restarted whenever the memory is not stalling a wait cycle
  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/dmem_block_mover.sv
// dmem_block_mover: word COPY/FILL engine driving the data-memory port
module dmem_block_mover import dmem_pkg::*; #(
  parameter int ADDR_W        = 32,
  parameter int LEN_W         = 16,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [31:0]       cfg_fill,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_stall
);
  state_e            state;
  logic              mode;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  rem;
  logic [31:0]       fill, data;
  logic              wt, stalled, expired, bad;
  assign mem_read      = state == RD_REQ || state == RD_WAIT;
  assign mem_write     = state == WR_REQ || state == WR_WAIT;
  assign wt            = state == RD_WAIT || state == WR_WAIT;
  assign stalled       = wt && mem_stall;
  assign busy          = mem_read || mem_write;
  assign done          = state == DONE;
  assign mem_addr      = mem_read ? src : mem_write ? dst : '0;
  assign mem_wdata     = mem_write ? (mode == MODE_FILL ? fill : data) : '0;
  assign mem_sign_mask = busy ? SM_WORD : 4'b0000;
  assign bad           = cfg_dst[1:0] != 2'b00 || (cfg_mode == MODE_COPY && cfg_src[1:0] != 2'b00);
  dmem_stall_timer #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!stalled),
    .en      (stalled),
    .expired (expired)
  );
  // transfer sequencing: latch config on start, step read/write accesses, finish via DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      err   <= 1'b0;
      mode  <= 1'b0;
      src   <= '0;
      dst   <= '0;
      rem   <= '0;
      fill  <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode  <= cfg_mode;
          src   <= {cfg_src[ADDR_W-1:2], 2'b00};
          dst   <= {cfg_dst[ADDR_W-1:2], 2'b00};
          rem   <= cfg_len;
          fill  <= cfg_fill;
          err   <= bad;
          state <= (bad || cfg_len == '0) ? DONE : cfg_mode == MODE_FILL ? WR_REQ : RD_REQ;
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: if (expired) begin
          err   <= 1'b1;
          state <= DONE;
        end else if (!mem_stall) begin
          data  <= mem_rdata;
          state <= WR_REQ;
        end
        WR_REQ: state <= WR_WAIT;
        WR_WAIT: if (expired) begin
          err   <= 1'b1;
          state <= DONE;
        end else if (!mem_stall) begin
          src   <= src + ADDR_W'(4);
          dst   <= dst + ADDR_W'(4);
          rem   <= rem - LEN_W'(1);
          state <= rem == LEN_W'(1) ? DONE : mode == MODE_FILL ? WR_REQ : RD_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_block_mover.sv
// tb_dmem_block_mover: randomized and directed checks against a word-level transfer model
module tb_dmem_block_mover;
  import dmem_pkg::*;
  logic        clk = 0, rst_n = 0, start = 0, cfg_mode = 0;
  logic [31:0] cfg_src = 0, cfg_dst = 0, cfg_fill = 0;
  logic [15:0] cfg_len = 0;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_rdata = 0;
  logic        mem_stall = 0;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  dmem_block_mover #(.STALL_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_fill(cfg_fill), .busy(busy), .done(done),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_sign_mask(mem_sign_mask), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall)
  );
  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  logic [31:0] mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  wr_t  wlog[$];
  int   stall_n = 0, ph = 0, req_cyc = 0, proto_bad = 0;
  logic prev_fin = 0;
  // memory model: each access stalls stall_n cycles starting the cycle after the request
  always @(posedge clk) begin
    #1;
    if (mem_read && mem_write) proto_bad++;
    if (!(mem_read || mem_write)) ph = 0;
    else begin
      ph = (ph == 0 || prev_fin) ? 1 : ph + 1;
      req_cyc++;
      if (mem_sign_mask != SM_WORD) proto_bad++;
    end
    mem_stall = ph >= 2 && ph - 1 <= stall_n;
    mem_rdata = (mem_read && mem.exists(mem_addr[31:2])) ? mem[mem_addr[31:2]] : 32'h0;
    prev_fin  = ph >= 2 && !mem_stall;
    if (prev_fin && mem_write) begin
      mem[mem_addr[31:2]] = mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic m, input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] n, input logic [31:0] f, input int st, input bit poke);
    bit bad, tmo, busy_seen;
    int exp_lat, lat;
    logic [31:0] sa, da, w;
    wr_t exp_q[$];
    bad = d[1:0] != 0 || (m == MODE_COPY && s[1:0] != 0);
    tmo = st >= 8 && !bad && n != 0;
    sa = s & ~32'h3;
    da = d & ~32'h3;
    if (!bad && !tmo)
      for (int i = 0; i < int'(n); i++) begin
        w = m ? f : (ref_mem.exists(sa[31:2]) ? ref_mem[sa[31:2]] : 32'h0);
        ref_mem[da[31:2]] = w;
        exp_q.push_back({da, w});
        sa += 4;
        da += 4;
      end
    exp_lat = (bad || n == 0) ? 1 : tmo ? 10 : (m ? 1 : 2) * int'(n) * (2 + st) + 1;
    @(negedge clk);
    stall_n = st;
    wlog.delete();
    req_cyc = 0;
    cfg_mode = m; cfg_src = s; cfg_dst = d; cfg_len = n; cfg_fill = f;
    start = 1;
    @(negedge clk);
    start = 0;
    cfg_dst = 32'h300; cfg_len = 16'd2; cfg_fill = ~f; cfg_mode = MODE_FILL;
    lat = 1;
    busy_seen = 0;
    while (!done && lat < 3000) begin
      busy_seen |= busy;
      start = poke && lat == 3;
      @(negedge clk);
      lat++;
    end
    start = 0;
    chk("latency", lat, exp_lat);
    chk("err", err, bad || tmo);
    chk("busy_seen", busy_seen, !(bad || n == 0));
    chk("req_cycles", req_cyc, exp_lat - 1);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("busy_after", busy, 0);
    chk("nwrites", wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      chk("waddr", wlog[i].a, exp_q[i].a);
      chk("wdata", wlog[i].d, exp_q[i].d);
    end
  endtask
  initial begin
    int bad_words;
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 3; i++) begin
      mem[i] = i + 1;
      ref_mem[i] = i + 1;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", {mem_read, mem_write, mem_sign_mask}, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1;
    run(MODE_FILL, 32'h0, 32'h100, 4, 32'hDEADBEEF, 0, 0);
    run(MODE_COPY, 32'h0, 32'h40, 3, 32'h0, 3, 0);
    run(MODE_COPY, 32'h10, 32'h20, 0, 32'h0, 0, 0);
    run(MODE_FILL, 32'h0, 32'h102, 2, 32'h1234, 0, 0);
    run(MODE_FILL, 32'h0, 32'h180, 3, 32'hA5A5A5A5, 1, 1);
    run(MODE_COPY, 32'h3, 32'h80, 1, 32'h0, 0, 0);
    run(MODE_FILL, 32'h0, 32'hFFFF_FFF8, 4, 32'h0BAD_F00D, 0, 0);
    run(MODE_FILL, 32'h0, 32'h1C0, 1, 32'h5555, 20, 0);
    run(MODE_COPY, 32'h8, 32'h1C4, 2, 32'h0, 20, 0);
    run(MODE_FILL, 32'h0, 32'h1C0, 1, 32'h7777, 0, 0);
    @(negedge clk);
    stall_n = 3;
    wlog.delete();
    cfg_mode = MODE_COPY; cfg_src = 32'h0; cfg_dst = 32'h60; cfg_len = 3;
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("rdwait_read", mem_read, 1);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_req", {mem_read, mem_write, mem_sign_mask}, 0);
    chk("midrst_flags", {busy, done, err}, 0);
    chk("midrst_addr", mem_addr, 0);
    @(negedge clk);
    chk("midrst_nodone", done, 0);
    rst_n = 1;
    chk("midrst_nowrite", wlog.size(), 0);
    run(MODE_COPY, 32'h0, 32'h60, 3, 32'h0, 2, 0);
    for (int k = 0; k < 10; k++)
      run(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63) * 4), 32'($urandom_range(0, 63) * 4),
          16'($urandom_range(1, 6)), $urandom, $urandom_range(0, 4), 0);
    bad_words = 0;
    for (int i = 0; i < 128; i++)
      if (mem[i] !== ref_mem[i]) bad_words++;
    chk("mem_image", bad_words, 0);
    chk("protocol", proto_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
